// File: rtl/uart_pkg.sv
// Shared UART state encodings and bit-timing helper.
// Optional even parity: define UART_PARITY_EN.
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;
`endif

    function automatic int cycles_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop on a full FIFO frees room
// for a push in the same cycle, a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_fifo_link.sv
// UART transmitter/receiver with TX and RX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_fifo_link
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic                 serial_out,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 err_clear
);
    localparam int CPB   = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2);
    localparam logic [2:0] DB_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] SB_LAST = 3'(STOP_BITS - 1);

    // FIFOs
    logic                 tx_full, tx_empty, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_full, rx_empty, rx_push;
    logic [DATA_BITS-1:0] rx_byte;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push_i(tx_valid), .push_data_i(tx_data), .full_o(tx_full),
        .pop_i(tx_pop), .pop_data_o(tx_head), .empty_o(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push_i(rx_push), .push_data_i(rx_byte), .full_o(rx_full),
        .pop_i(rx_ready), .pop_data_o(rx_data), .empty_o(rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    // Transmitter
    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line, tx_last;

    assign tx_last = (tx_cnt_q == LAST);

`ifdef UART_PARITY_EN
    logic tx_par_q, tx_par_d;
    assign tx_par_d = tx_pop ? ^tx_head : tx_par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
            TX_DATA: begin
                tx_line = tx_shift_q[0];
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DB_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end else tx_bit_d = tx_bit_q + 3'd1;
                end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx_line = tx_par_q;
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
`endif
            TX_STOP: begin
                if (tx_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == SB_LAST) begin
                        tx_bit_d = '0;
                        // chain straight into the next start bit when data is waiting
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_head;
                            tx_state_d = TX_START;
                        end else tx_state_d = TX_IDLE;
                    end else tx_bit_d = tx_bit_q + 3'd1;
                end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign serial_out = tx_line;

    // Receiver
    logic                 sync1_q, sync2_q, prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 rx_last, byte_ok, frame_evt, par_evt, overrun_evt;

    assign rx_last = (rx_cnt_q == LAST);
    assign rx_byte = rx_shift_q;

`ifdef UART_PARITY_EN
    logic par_bad_q, par_bad_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            stop_bad_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            sync1_q    <= serial_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            stop_bad_q <= stop_bad_d;
`ifdef UART_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        stop_bad_d = stop_bad_q;
        byte_ok    = 1'b0;
        frame_evt  = 1'b0;
        par_evt    = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                // counter starts at 1 so the start re-sample lands on the bit midpoint
                if (prev_q && !sync2_q) begin
                    rx_cnt_d   = CNT_W'(1);
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q >= HALF) begin
                    if (sync2_q) rx_state_d = RX_IDLE;
                    else begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
`ifdef UART_PARITY_EN
                        par_bad_d  = 1'b0;
`endif
                    end
                end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
            RX_DATA: begin
                if (rx_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DB_LAST) begin
                        rx_bit_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else rx_bit_d = rx_bit_q + 3'd1;
                end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_last) begin
                    rx_cnt_d   = '0;
                    par_bad_d  = (sync2_q != ^rx_shift_q);
                    par_evt    = par_bad_d;
                    rx_state_d = RX_STOP;
                end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
`endif
            RX_STOP: begin
                // after a bad stop bit, hold here until the line returns high
                if (stop_bad_q) begin
                    if (sync2_q) begin
                        stop_bad_d = 1'b0;
                        rx_state_d = RX_IDLE;
                    end
                end else if (rx_last) begin
                    rx_cnt_d = '0;
                    if (sync2_q) begin
                        rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                        byte_ok    = !par_bad_q;
`else
                        byte_ok    = 1'b1;
`endif
                    end else begin
                        frame_evt  = 1'b1;
                        stop_bad_d = 1'b1;
                    end
                end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_push     = byte_ok;
    assign overrun_evt = byte_ok && rx_full && !rx_ready;

    // Sticky error flags: an event in the clearing cycle keeps the flag set
    logic ovr_q, ovr_d, ferr_q, ferr_d;
    assign ovr_d  = overrun_evt || (ovr_q && !err_clear);
    assign ferr_d = frame_evt || (ferr_q && !err_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
    end

    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;

`ifdef UART_PARITY_EN
    logic perr_q, perr_d;
    assign perr_d = par_evt || (perr_q && !err_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign rx_parity_err = perr_q;
`else
    logic unused_par;
    assign unused_par    = par_evt;
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_link.sv
// Randomized self-checking bench for uart_fifo_link (5 cycles/bit, 4-deep FIFOs).
// Parity scenarios are included when UART_PARITY_EN is defined.
module tb_uart_fifo_link;
    localparam int CPB   = 5;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_BITS = 1 + DB + PB + 1;

    logic       clk = 1'b0;
    logic       rst, serial_in, serial_out;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       rx_overrun, rx_frame_err, rx_parity_err, err_clear;
    logic       loop_en, drv_line;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic       exp_ovr;

    assign serial_in = loop_en ? serial_out : drv_line;

    always #10 clk = ~clk;

    uart_fifo_link #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE(10_000_000),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .serial_in(serial_in), .serial_out(serial_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .err_clear(err_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level of frame bit idx: start, data LSB first, [even parity], stop
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return b[idx-1];
        if (PB == 1 && idx == DB + 1) return ^b;
        return 1'b1;
    endfunction

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic expect_tx_frame(input logic [7:0] b, input bit wait_start);
        int n;
        if (wait_start) begin
            n = 0;
            while (serial_out !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                check("tx_start_timeout", 32'd0, 32'd1);
                return;
            end
        end else @(negedge clk);
        for (int i = 0; i < FRAME_BITS * CPB; i++) begin
            if (i > 0) @(negedge clk);
            check("tx_line", {31'd0, serial_out}, {31'd0, frame_bit(b, i / CPB)});
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_v, input logic stop_v);
        logic v;
        for (int i = 0; i < FRAME_BITS; i++) begin
            v = frame_bit(b, i);
            if (PB == 1 && i == DB + 1) v = par_v;
            if (i == FRAME_BITS - 1) v = stop_v;
            drv_line = v;
            repeat (CPB) @(negedge clk);
        end
        drv_line = 1'b1;
    endtask

    task automatic pop_rx(input logic [7:0] e);
        check("rx_valid", {31'd0, rx_valid}, 32'd1);
        check("rx_data", {24'd0, rx_data}, {24'd0, e});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain_model;
        while (exp_q.size() > 0) pop_rx(exp_q.pop_front());
        check("rx_empty", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic pulse_clear;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] b;

        rst = 1'b1; loop_en = 1'b1; drv_line = 1'b1;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clear = 1'b0;
        exp_ovr = 1'b0;

        @(negedge clk);
        check("rst_serial_out", {31'd0, serial_out}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single loopback frame
        fork
            push_tx(8'h61);
            expect_tx_frame(8'h61, 1'b1);
        join
        exp_q.push_back(8'h61);
        repeat (10) @(negedge clk);
        drain_model();

        // Back-to-back frames: fixed pattern then random bytes
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < 4; k++)
                bytes[k] = (round == 0) ? 8'((k == 3) ? 8'h3e : ((k == 1) ? 8'h35 : 8'h31))
                                        : 8'($urandom_range(0, 255));
            fork
                begin
                    for (int k = 0; k < 4; k++) push_tx(bytes[k]);
                end
                begin
                    expect_tx_frame(bytes[0], 1'b1);
                    for (int k = 1; k < 4; k++) expect_tx_frame(bytes[k], 1'b0);
                end
            join
            for (int k = 0; k < 4; k++) exp_q.push_back(bytes[k]);
            @(negedge clk);
            check("tx_idle_after", {31'd0, serial_out}, 32'd1);
            repeat (10) @(negedge clk);
            drain_model();
        end

        // Overrun: five externally driven frames with nobody popping
        loop_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, ^b, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr = 1'b1;
            repeat (3) @(negedge clk);
            check("rx_overrun", {31'd0, rx_overrun}, {31'd0, exp_ovr});
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        check("frame_err_clean", {31'd0, rx_frame_err}, 32'd0);
        drain_model();
        check("overrun_held", {31'd0, rx_overrun}, 32'd1);
        pulse_clear();
        check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);

        // Bad stop bit, then a short glitch, then a good frame
        send_frame(8'h55, ^8'h55, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err_set", {31'd0, rx_frame_err}, 32'd1);
        check("frame_err_no_byte", {31'd0, rx_valid}, 32'd0);
        pulse_clear();
        check("frame_err_cleared", {31'd0, rx_frame_err}, 32'd0);
        drv_line = 1'b0;
        repeat (2) @(negedge clk);
        drv_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_byte", {31'd0, rx_valid}, 32'd0);
        check("glitch_no_err", {31'd0, rx_frame_err}, 32'd0);
        b = 8'($urandom_range(0, 255));
        send_frame(b, ^b, 1'b1);
        exp_q.push_back(b);
        repeat (3) @(negedge clk);
        drain_model();

`ifdef UART_PARITY_EN
        send_frame(8'h31, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("parity_err_set", {31'd0, rx_parity_err}, 32'd1);
        check("parity_err_no_byte", {31'd0, rx_valid}, 32'd0);
        pulse_clear();
        check("parity_err_cleared", {31'd0, rx_parity_err}, 32'd0);
        send_frame(8'h31, 1'b1, 1'b1);
        exp_q.push_back(8'h31);
        repeat (3) @(negedge clk);
        check("parity_ok_no_err", {31'd0, rx_parity_err}, 32'd0);
        drain_model();
`else
        check("parity_tied_low", {31'd0, rx_parity_err}, 32'd0);
`endif

        // Reset in the middle of data bit 3 of a looped-back frame
        loop_en = 1'b1;
        b = 8'($urandom_range(0, 255));
        fork
            push_tx(b);
            begin
                int n;
                n = 0;
                while (serial_out !== 1'b0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) check("rst_start_timeout", 32'd0, 32'd1);
            end
        join
        repeat (CPB * 4) @(negedge clk);
        check("pre_rst_bit3", {31'd0, serial_out}, {31'd0, b[3]});
        rst = 1'b1;
        #1;
        check("mid_rst_serial_out", {31'd0, serial_out}, 32'd1);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_no_byte", {31'd0, rx_valid}, 32'd0);
        check("post_rst_line_idle", {31'd0, serial_out}, 32'd1);
        check("post_rst_no_err", {30'd0, rx_frame_err, rx_overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_fifo_link.md
UART_FIFO_LINK -- requirements
Module: uart_fifo_link

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 10_000_000, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload width, legal 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits transmitted, legal 1..2; RX checks only the first.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX/RX FIFO, power of 2, at least 2.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on posedge.
REQ-007 SHALL have port rst, input, 1, meaning reset; reset is asynchronous and active-high.
REQ-008 SHALL have ports serial_in (input, 1, RX line) and serial_out (output, 1, TX line, idle high).
REQ-009 SHALL have ports tx_data (input, DATA_BITS), tx_valid (input, 1) and tx_ready (output, 1), forming the TX FIFO push handshake.
REQ-010 SHALL have ports rx_data (output, DATA_BITS), rx_valid (output, 1) and rx_ready (input, 1), forming the RX FIFO pop handshake.
REQ-011 SHALL have outputs rx_overrun, rx_frame_err and rx_parity_err (1 bit each, sticky error flags), and input err_clear (1 bit, clears all flags).

Function
REQ-012 SHALL derive CYC_PER_BIT = CLOCK_FREQ/BAUD_RATE; each line bit SHALL last exactly CYC_PER_BIT cycles.
REQ-013 SHALL transfer when valid&&ready on a posedge; tx_ready=!tx_full; rx_valid=!rx_empty; rx_data shows the FIFO head combinationally.
REQ-014 TX FSM SHALL be IDLE->START->DATA->[PARITY]->STOP->IDLE; it leaves IDLE the cycle after the TX FIFO is non-empty, popping one entry.
REQ-015 TX SHALL send start 0, data LSB first, then STOP_BITS ones; back-to-back frames SHALL have no extra idle bit.
REQ-016 serial_in SHALL pass a 2-flop synchroniser; RX FSM SHALL be IDLE->START->DATA->[PARITY]->STOP->IDLE.
REQ-017 RX SHALL detect a start on a synchronised falling edge; at CYC_PER_BIT/2 it re-samples, returning to IDLE if high (glitch reject).
REQ-018 RX SHALL sample each later bit at its midpoint.
REQ-019 STOP sample 0 SHALL set rx_frame_err and discard the byte; the FSM SHALL wait for the line high before re-entering IDLE.
REQ-020 A valid byte arriving with the RX FIFO full SHALL be dropped and set rx_overrun; FIFO contents are unchanged.
REQ-021 Simultaneous push and pop on a full or empty FIFO SHALL both succeed if legal per flags (full: pop then push; empty: push only).
REQ-022 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wrapping modulo 2*FIFO_DEPTH; full/empty SHALL use the MSB compare.
REQ-023 err_clear SHALL clear the flags the next cycle; an error event in the same cycle SHALL win (flag stays 1).

Reset
REQ-024 On rst, serial_out=1, tx_ready=1, rx_valid=0, all error flags=0, both FSMs=IDLE, FIFOs empty, synchroniser=1, all immediately.
REQ-025 Reset mid-frame SHALL abort the frame without completing it; no partial byte reaches the RX FIFO.

Configuration
REQ-026 With UART_PARITY_EN defined, TX SHALL insert an even-parity bit after data and RX SHALL check it, setting rx_parity_err and discarding the byte on mismatch.
REQ-027 Without UART_PARITY_EN, the PARITY state and logic SHALL be absent and rx_parity_err SHALL be tied 0.

Structure
REQ-028 Package uart_pkg SHALL hold the TX/RX state enums and a cycles-per-bit helper function.
REQ-029 Sub-module sync_fifo (parameter WIDTH, DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification (CLOCK_FREQ 50 MHz, BAUD_RATE 10 MHz, 5 cycles/bit, FIFO_DEPTH 4)
REQ-030 Push 8'h61 with serial_out looped to serial_in -> serial_out low for exactly 5 cycles, then pattern 1,0,0,0,0,1,1,0; rx_data=8'h61 with rx_valid=1.
REQ-031 Push 8'h31,8'h35,8'h31,8'h3e back-to-back -> frames contiguous (40 bit-times total); RX pops the same 4 bytes in order.
REQ-032 Drive 5 frames in with rx_ready=0 -> FIFO holds the first 4, rx_overrun=1; pulse err_clear -> rx_overrun=0.
REQ-033 Drive frame 8'h55 with stop bit 0 -> rx_frame_err=1, rx_valid stays 0; a 2-cycle low glitch -> no frame, no error.
REQ-034 With UART_PARITY_EN defined, drive 8'h31 with parity bit 0 -> rx_parity_err=1, byte dropped; with parity 1 -> byte accepted.
REQ-035 Assert rst during DATA bit 3 of a TX frame -> serial_out=1 in the same cycle; no RX byte is queued.
